// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - interrupt delivery interface between an interrupt source and its sink
interface irq_ctrl_if #(
    parameter int N      = 32,
    parameter int PRIO_W = 2
);
    localparam int VEC_W    = (N <= 1) ? 1 : $clog2(N);
    localparam int PRIO_W_E = (PRIO_W < 1) ? 1 : PRIO_W;

    logic                irq_valid;
    logic [VEC_W-1:0]    irq_vector;
    logic [PRIO_W_E-1:0] irq_prio;
    logic                irq_ack;
    logic [VEC_W-1:0]    irq_ack_vector;
    logic                eoi_valid;
    logic [VEC_W-1:0]    eoi_vector;

    modport master (
        output irq_valid, irq_vector, irq_prio,
        input  irq_ack, irq_ack_vector, eoi_valid, eoi_vector
    );

    modport slave (
        input  irq_valid, irq_vector, irq_prio,
        output irq_ack, irq_ack_vector, eoi_valid, eoi_vector
    );
endinterface

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - priority interrupt controller, level/edge pending, masked arbitration, ack retire
// Optional in-service nesting enabled by defining CARBON_IRQ_CTRL_INSVC_EN.
module irq_ctrl #(
    parameter int  N        = 32,
    parameter int  PRIO_W   = 2,
    localparam int VEC_W    = (N <= 1) ? 1 : $clog2(N),
    localparam int PRIO_W_E = (PRIO_W < 1) ? 1 : PRIO_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_src,
    input  logic             i_cfg_we,
    input  logic [1:0]       i_cfg_sel,
    input  logic [VEC_W-1:0] i_cfg_idx,
    input  logic [N-1:0]     i_cfg_wdata,
    output logic [N-1:0]     o_irq_pending,
    output logic             o_ack_err,
    output logic [N-1:0]     o_insvc,
    irq_ctrl_if.master       irq
);

    logic [N-1:0]        r_enable;
    logic [N-1:0]        r_edge;
    logic [N-1:0]        r_pending;
    logic [N-1:0]        r_src_q;
    logic [PRIO_W_E-1:0] r_prio [N];

    logic                r_valid;
    logic [VEC_W-1:0]    r_vector;
    logic [PRIO_W_E-1:0] r_prio_out;
    logic                r_ack_err;

    logic                w_ack_ok;
    logic [N-1:0]        w_ack_clr;
    logic [N-1:0]        w_eligible;
    logic [N-1:0]        w_cand;
    logic                w_found;
    logic [VEC_W-1:0]    w_win_idx;
    logic [PRIO_W_E-1:0] w_win_prio;
    logic [N-1:0]        w_sw_set;
    logic [N-1:0]        w_edge_next;
    logic [N-1:0]        w_mode_chg;
    logic [N-1:0]        w_pend_next;

`ifdef CARBON_IRQ_CTRL_INSVC_EN
    logic [N-1:0]        r_insvc;
    logic [N-1:0]        w_insvc_next;
    logic [PRIO_W_E-1:0] w_insvc_max;

    always_comb begin
        w_insvc_max = '0;
        for (int i = 0; i < N; i++) begin
            if (r_insvc[i] && (r_prio[i] > w_insvc_max))
                w_insvc_max = r_prio[i];
        end
        for (int i = 0; i < N; i++)
            w_eligible[i] = (r_insvc == '0) || (r_prio[i] > w_insvc_max);
        // EOI first, then the ack set on top so a same-vector ack wins
        w_insvc_next = r_insvc;
        for (int i = 0; i < N; i++) begin
            if (irq.eoi_valid && (irq.eoi_vector == VEC_W'(i)))
                w_insvc_next[i] = 1'b0;
        end
        w_insvc_next = w_insvc_next | w_ack_clr;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_insvc <= '0;
        else     r_insvc <= w_insvc_next;
    end

    assign o_insvc = r_insvc;
`else
    logic w_unused_eoi;

    assign w_unused_eoi = irq.eoi_valid ^ (^irq.eoi_vector);
    assign w_eligible   = '1;
    assign o_insvc      = '0;
`endif

    always_comb begin
        w_ack_ok = irq.irq_ack && r_valid && (irq.irq_ack_vector == r_vector);
        for (int i = 0; i < N; i++)
            w_ack_clr[i] = w_ack_ok && (r_vector == VEC_W'(i));
    end

    // Descending scan with >= leaves the lowest index holding a priority tie
    always_comb begin
        w_cand     = r_pending & r_enable & w_eligible;
        w_found    = 1'b0;
        w_win_idx  = '0;
        w_win_prio = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_cand[i] && (!w_found || (r_prio[i] >= w_win_prio))) begin
                w_found    = 1'b1;
                w_win_idx  = VEC_W'(i);
                w_win_prio = r_prio[i];
            end
        end
    end

    always_comb begin
        w_sw_set    = (i_cfg_we && (i_cfg_sel == 2'd2)) ? i_cfg_wdata : '0;
        w_edge_next = (r_pending & ~w_ack_clr) | (i_src & ~r_src_q) | w_sw_set;
        w_pend_next = (r_edge & w_edge_next) | (~r_edge & i_src);
        w_mode_chg  = '0;
        if (i_cfg_we && (i_cfg_sel == 2'd1))
            w_mode_chg = i_cfg_wdata ^ r_edge;
        // Bits switching trigger mode hold their pending value for this cycle
        w_pend_next = (w_pend_next & ~w_mode_chg) | (r_pending & w_mode_chg);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_enable   <= '0;
            r_edge     <= '0;
            r_pending  <= '0;
            r_src_q    <= '0;
            for (int i = 0; i < N; i++)
                r_prio[i] <= '0;
            r_valid    <= 1'b0;
            r_vector   <= '0;
            r_prio_out <= '0;
            r_ack_err  <= 1'b0;
        end else begin
            r_src_q   <= i_src;
            r_pending <= w_pend_next;
            if (i_cfg_we && (i_cfg_sel == 2'd0)) r_enable <= i_cfg_wdata;
            if (i_cfg_we && (i_cfg_sel == 2'd1)) r_edge   <= i_cfg_wdata;
            for (int i = 0; i < N; i++) begin
                if ((PRIO_W > 0) && i_cfg_we && (i_cfg_sel == 2'd3) && (i_cfg_idx == VEC_W'(i)))
                    r_prio[i] <= i_cfg_wdata[PRIO_W_E-1:0];
            end
            r_ack_err <= irq.irq_ack && !w_ack_ok;
            // An accepted ack forces one idle cycle before re-arbitration
            if (w_ack_ok) begin
                r_valid <= 1'b0;
            end else begin
                r_valid    <= w_found;
                r_vector   <= w_win_idx;
                r_prio_out <= w_win_prio;
            end
        end
    end

    assign irq.irq_valid  = r_valid;
    assign irq.irq_vector = r_vector;
    assign irq.irq_prio   = r_prio_out;
    assign o_irq_pending  = r_pending;
    assign o_ack_err      = r_ack_err;

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
Priority interrupt controller. It drives the source side of the common interrupt delivery interface.
- Latches N synchronous request lines as level- or edge-triggered pending bits.
- Masks pending bits with a per-source enable.
- Presents one highest-priority vector at a time and retires it on a matching ack.
- A single-write config port programs the enable mask, trigger mode, per-vector priority and software-set pending.

Parameters:
N, 32, number of interrupt sources; VEC_W = (N<=1) ? 1 : clog2(N).
PRIO_W, 2, priority width; 0 means flat priority; PRIO_W_E = max(PRIO_W,1).

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
src_i  in  N  raw request lines, already synchronous to clk.
cfg_we  in  1  config write strobe, single cycle.
cfg_sel  in  2  target: 0=enable mask, 1=edge-mode mask, 2=sw set pending, 3=priority of vector cfg_idx.
cfg_idx  in  VEC_W  vector index for cfg_sel=3.
cfg_wdata  in  N  write data; cfg_sel=3 uses bits [PRIO_W_E-1:0].
irq_valid  out  1  vector presented.
irq_vector  out  VEC_W  presented vector.
irq_prio  out  PRIO_W_E  priority of presented vector.
irq_pending  out  N  raw pending register, unmasked.
irq_ack  in  1  sink accepts the presented vector.
irq_ack_vector  in  VEC_W  vector being acked.
ack_err  out  1  one-cycle pulse when an ack is ignored.
eoi_valid  in  1  end-of-interrupt strobe (used only with the optional feature).
eoi_vector  in  VEC_W  vector being retired.
insvc  out  N  in-service bitmap.

Behaviour:
- Reset (async on rst=1): all config and state registers clear to 0 (enable, edge, prio, pending, src_q, insvc); irq_valid, irq_vector, irq_prio and ack_err drive 0.
- src_q is src_i registered each cycle.
- Level bits (edge=0): pending[i] <= src_i[i] every cycle. Ack does not clear a level bit. Software set is ignored for level bits.
- Edge bits (edge=1):
  - Set condition: src_i & ~src_q, or a software set with cfg_sel=2 (cfg_wdata ORed in).
  - Clear condition: accepted ack of that vector.
  - Set and clear in the same cycle: set wins.
- Mode change: writing edge leaves pending unchanged for one cycle; the new rule applies from the next edge.
- cfg_sel=3: prio[cfg_idx] <= cfg_wdata[PRIO_W_E-1:0]. Ignored if PRIO_W=0 or cfg_idx>=N.
- Arbitration:
  - Candidate set = pending & enable.
  - Winner = highest prio; ties go to the lowest index.
  - Outputs are registered from that cycle's candidates.
- Latency: src_i edge sampled at clock k -> pending set at k -> irq_valid=1 at k+1. Config writes take effect on arbitration the cycle after the write.
- Re-evaluation: the presented vector is recomputed every cycle, so a higher-priority arrival preempts before ack. If the candidate set becomes empty, irq_valid drops next cycle.
- Ack accepted iff irq_ack && irq_valid && irq_ack_vector==irq_vector. On acceptance:
  - the edge pending bit clears;
  - irq_valid is forced 0 the next cycle;
  - arbitration resumes the cycle after that, giving a mandatory 1-cycle bubble.
- Any other irq_ack=1: no state change; ack_err=1 for one cycle.
- PRIO_W=0: irq_prio is always 0; ordering is purely by index.
- Reset mid-presentation: irq_valid drops immediately (async) and all pending bits are lost.

Optional Feature:
Macro: CARBON_IRQ_CTRL_INSVC_EN.
- With the macro:
  - An accepted ack sets insvc[vector].
  - A candidate is eligible only if its prio is strictly greater than the highest prio currently in service, or if insvc is empty.
  - eoi_valid clears insvc[eoi_vector]; EOI of a vector not in service is ignored.
  - EOI and ack of the same vector in the same cycle: ack wins.
- Without the macro: insvc is tied to 0, eoi_* are ignored, and there is no nesting restriction.

Test Plan:
1. Edge, prio: enable=0x3, edge=0x3, prio[0]=1, prio[1]=3; pulse src_i[0] and src_i[1] in the same cycle -> two cycles later irq_vector=1, irq_prio=3; ack vector 1 -> one bubble cycle, then irq_vector=0, irq_prio=1.
2. Level hold: edge=0, enable bit 5, src_i[5] held high; ack vector 5 -> irq_valid returns after the bubble, still vector 5; drop src_i[5] -> irq_valid=0 two cycles later.
3. Bad ack: irq_vector=2 presented; ack with irq_ack_vector=3 -> ack_err pulse, pending[2] stays 1, presentation unchanged. Ack while irq_valid=0 -> ack_err pulse, no state change.
4. Tie and mask: vectors 4 and 9 both prio 2 and pending -> vector 4 presented; clear enable bit 4 -> vector 9 presented the following cycle.
5. Simultaneous set/clear: a new rising edge on src_i[7] in the cycle vector 7 is acked -> pending[7] remains 1 and is re-presented after the bubble.
6. INSVC_EN: ack vector 1 (prio 1); vector 2 (prio 1) pending -> not presented; vector 3 (prio 2) -> presented; EOI vector 1 after vector 3's EOI -> vector 2 presented.
